dmem_store_buffer: RTL

//  Sits between the core's data-memory port and a handshaked data bus. Posts stores into a

---
 rtl/dmem_store_buffer.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - posted-store FIFO and blocking-load bridge between core dmem port and data bus
// Optional feature macro: STORE_BYPASS_EN (loads overtake queued stores to other words)

module dmem_store_buffer #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_dmem_writeb,
  input  logic        i_dmem_read,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  output logic [31:0] o_dmem_rdata,
  output logic        o_stall,
  output logic        o_sb_empty,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WR    = 2'd1,
    S_RD    = 2'd2,
    S_RDONE = 2'd3
  } state_t;

  localparam logic [DEPTH_LOG2:0] L_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

  state_t r_state;
  state_t w_next_state;

  // Store FIFO: word address, byte enables, lane-aligned data
  logic [29:0]           r_fifo_addr [DEPTH];
  logic [3:0]            r_fifo_be   [DEPTH];
  logic [31:0]           r_fifo_data [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;

  // Registered bus and load-return outputs
  logic        r_mem_req;
  logic        r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_dmem_rdata;

  logic w_store_req;
  logic w_full;
  logic w_enq;
  logic w_deq;
  logic w_xfer_done;
  logic w_load_ok;
  logic w_load_go;
  logic w_issue_wr;
  logic w_issue_rd;
  logic w_unused;

  // The bus works on whole words; the core keeps the byte offset for lane extraction
  assign w_unused = ^i_dmem_addr[1:0];

  assign w_store_req = |i_dmem_writeb;
  assign w_full      = (r_count == L_DEPTH);
  // A full FIFO blocks the store for the whole cycle, even if the head retires on this edge
  assign w_enq       = w_store_req && !w_full;
  assign w_xfer_done = r_mem_req && i_mem_ack;
  assign w_deq       = (r_state == S_WR) && w_xfer_done;

`ifdef STORE_BYPASS_EN
  logic [DEPTH-1:0] w_entry_valid;
  logic             w_addr_match;

  // Mark live FIFO slots and look for a queued store to the load's word
  always_comb begin
    w_entry_valid = '0;
    w_addr_match  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_valid[i] = ({1'b0, DEPTH_LOG2'(i) - r_rptr} < r_count);
      if (w_entry_valid[i] && (r_fifo_addr[i] == i_dmem_addr[31:2])) begin
        w_addr_match = 1'b1;
      end
    end
  end

  // Loads go ahead of draining stores unless an older store targets the same word
  assign w_load_ok = (r_state == S_IDLE) && !w_addr_match;
`else
  // Loads only issue once every posted store has reached the bus
  assign w_load_ok = (r_state == S_IDLE) && (r_count == '0);
`endif

  assign w_load_go  = i_dmem_read && w_load_ok;
  assign w_issue_wr = (r_state == S_IDLE) && (w_next_state == S_WR);
  assign w_issue_rd = (r_state == S_IDLE) && (w_next_state == S_RD);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; every transfer returns through IDLE so transfers never run back-to-back
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_load_go) begin
          w_next_state = S_RD;
        end else if (r_count != '0) begin
          w_next_state = S_WR;
        end
      end
      S_WR: begin
        if (w_xfer_done) begin
          w_next_state = S_IDLE;
        end
      end
      S_RD: begin
        if (w_xfer_done) begin
          w_next_state = S_RDONE;
        end
      end
      S_RDONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Core-facing status: stall on a full-FIFO store or on any load until its data is presented
  always_comb begin
    o_stall    = (w_store_req && w_full) ||
                 (r_state == S_RD) ||
                 (i_dmem_read && (r_state != S_RDONE));
    o_sb_empty = (r_count == '0) && (r_state != S_WR);
  end

  // FIFO storage write; contents need no reset because the pointers and count qualify them
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_fifo_addr[r_wptr] <= i_dmem_addr[31:2];
      r_fifo_be[r_wptr]   <= i_dmem_writeb;
      r_fifo_data[r_wptr] <= i_dmem_wdata;
    end
  end

  // FIFO pointers and occupancy; simultaneous enqueue and dequeue leave the count unchanged
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Bus outputs are loaded at issue and held unchanged until the transfer is accepted
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
    end else if (w_issue_wr) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b1;
      r_mem_be    <= r_fifo_be[r_rptr];
      r_mem_addr  <= {r_fifo_addr[r_rptr], 2'b00};
      r_mem_wdata <= r_fifo_data[r_rptr];
    end else if (w_issue_rd) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'hF;
      r_mem_addr  <= {i_dmem_addr[31:2], 2'b00};
    end else if (w_xfer_done) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Capture load data in the acknowledge cycle; it is presented during RDONE
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dmem_rdata <= 32'h0;
    end else if ((r_state == S_RD) && w_xfer_done) begin
      r_dmem_rdata <= i_mem_rdata;
    end
  end

  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_be     = r_mem_be;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_dmem_rdata = r_dmem_rdata;

  // Bus request must stay stable until the bus accepts it
  assert property (@(posedge i_clk) disable iff (i_reset)
    (r_mem_req && !i_mem_ack) |=> (r_mem_req && $stable(r_mem_we) && $stable(r_mem_be) &&
                                   $stable(r_mem_addr) && $stable(r_mem_wdata)));

  // Occupancy can never exceed the FIFO size
  assert property (@(posedge i_clk) disable iff (i_reset) (r_count <= L_DEPTH));

  // The core never requests a load and a store in the same cycle
  assert property (@(posedge i_clk) disable iff (i_reset) !(w_store_req && i_dmem_read));

endmodule
